// File: rtl/ofm_writer_if.sv
// Bus bundle for ofm_writer: dual-port kernel sample input and valid/ready memory-write output.
interface ofm_writer_if #(
  parameter int unsigned OUT_DW = 25,
  parameter int unsigned ADDR_W = 18
);
  logic [OUT_DW-1:0] ofm_port0;
  logic [OUT_DW-1:0] ofm_port1;
  logic              ofm_port0_v;
  logic              ofm_port1_v;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_DW-1:0] wr_data;

  // master: the writer block; slave: kernel + memory side
  modport master (
    input  ofm_port0, ofm_port1, ofm_port0_v, ofm_port1_v, wr_ready,
    output wr_valid, wr_addr, wr_data
  );
  modport slave (
    output ofm_port0, ofm_port1, ofm_port0_v, ofm_port1_v, wr_ready,
    input  wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/ofm_writer.sv
// Collects tile-ordered conv output beats, maps them to raster addresses and writes them out via a FIFO.
// Optional feature: define OFM_WRITER_RELU_EN to clamp negative samples to zero at push time.
module ofm_writer #(
  parameter int unsigned OUT_DW     = 25,
  parameter int unsigned TI         = 16,
  parameter int unsigned OFM_C      = 8,
  parameter int unsigned OFM_H      = 61,
  parameter int unsigned OFM_W      = 61,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  ofm_writer_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         err_overflow,
  output logic         err_proto
);

  localparam int unsigned TW    = (OFM_W + TI - 1) / TI;
  localparam int unsigned OW_W  = (TI > 1) ? $clog2(TI) : 1;
  localparam int unsigned OH_W  = $clog2(OFM_H + 2);
  localparam int unsigned TW_W  = $clog2(TW + 1);
  localparam int unsigned OC_W  = $clog2(OFM_C + 1);
  localparam int unsigned COL_W = $clog2(TW * TI + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] CH_SIZE  = ADDR_W'(OFM_H * OFM_W);
  localparam logic [ADDR_W-1:0] ROW_SIZE = ADDR_W'(OFM_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OUT_DW-1:0] data;
  } entry_t;

  state_t            state;
  logic [OW_W-1:0]   ow;
  logic [OH_W-1:0]   oh;
  logic [TW_W-1:0]   tw;
  logic [OC_W-1:0]   oc;

  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_valid_q;

  logic              pair_c;
  logic              adv_c;
  logic              proto_c;
  logic              pop_c;
  logic              push_c;
  logic              overflow_c;
  logic [COL_W-1:0]  col_c;
  logic [CNT_W-1:0]  need_c;
  logic [CNT_W-1:0]  free_c;
  logic [CNT_W-1:0]  n_push_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic [OH_W-1:0]   oh_step_c;
  logic [ADDR_W-1:0] addr0_c;
  logic [ADDR_W-1:0] addr1_c;
  logic [PTR_W-1:0]  wr_ptr_p1_c;

  function automatic logic [OUT_DW-1:0] shape(input logic [OUT_DW-1:0] s);
`ifdef OFM_WRITER_RELU_EN
    return s[OUT_DW-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  // Beat decode, FIFO space check and push addresses
  always_comb begin
    pair_c      = 1'b0;
    adv_c       = 1'b0;
    proto_c     = 1'b0;
    need_c      = '0;
    if (state == S_RUN) begin
      pair_c  = bus.ofm_port0_v & bus.ofm_port1_v;
      adv_c   = bus.ofm_port0_v;
      proto_c = ~bus.ofm_port0_v & bus.ofm_port1_v;
    end
    col_c       = COL_W'(tw) * COL_W'(TI) + COL_W'(ow);
    if (adv_c && (col_c < COL_W'(OFM_W)))
      need_c = pair_c ? CNT_W'(2) : CNT_W'(1);
    pop_c       = wr_valid_q & bus.wr_ready;
    free_c      = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop_c);
    overflow_c  = (need_c != '0) && (free_c < need_c);
    push_c      = (need_c != '0) && !overflow_c;
    n_push_c    = push_c ? need_c : '0;
    count_nxt_c = count + n_push_c - CNT_W'(pop_c);
    oh_step_c   = oh + (pair_c ? OH_W'(2) : OH_W'(1));
    addr0_c     = ADDR_W'(oc) * CH_SIZE + ADDR_W'(oh) * ROW_SIZE + ADDR_W'(col_c);
    addr1_c     = addr0_c + ROW_SIZE;
    wr_ptr_p1_c = wr_ptr + PTR_W'(1);
  end

  // Show-ahead FIFO; port0 entry lands first so it pops first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= '{addr: addr0_c, data: shape(bus.ofm_port0)};
        if (need_c == CNT_W'(2))
          mem[wr_ptr_p1_c] <= '{addr: addr1_c, data: shape(bus.ofm_port1)};
      end
      wr_ptr     <= wr_ptr + PTR_W'(n_push_c);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt_c;
      wr_valid_q <= (count_nxt_c != '0);
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = mem[rd_ptr].addr;
  assign bus.wr_data  = mem[rd_ptr].data;

  // Layer control and tile/row/channel counters; dropped beats still advance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ow           <= '0;
      oh           <= '0;
      tw           <= '0;
      oc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RUN;
            ow           <= '0;
            oh           <= '0;
            tw           <= '0;
            oc           <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_proto    <= 1'b0;
          end
        end
        S_RUN: begin
          if (proto_c)    err_proto    <= 1'b1;
          if (overflow_c) err_overflow <= 1'b1;
          if (adv_c) begin
            if (ow == OW_W'(TI - 1)) begin
              ow <= '0;
              if (oh_step_c >= OH_W'(OFM_H)) begin
                oh <= '0;
                if (tw == TW_W'(TW - 1)) begin
                  tw <= '0;
                  oc <= oc + OC_W'(1);
                  if (oc == OC_W'(OFM_C - 1)) state <= S_DRAIN;
                end else begin
                  tw <= tw + TW_W'(1);
                end
              end else begin
                oh <= oh_step_c;
              end
            end else begin
              ow <= ow + OW_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (count_nxt_c == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writer.sv
// Bench for ofm_writer: directed layer/backpressure/error/reset steps plus a random phase, scored per cycle.
module tb_ofm_writer;

  localparam int unsigned OUT_DW     = 25;
  localparam int unsigned TI         = 4;
  localparam int unsigned OFM_C      = 2;
  localparam int unsigned OFM_H      = 3;
  localparam int unsigned OFM_W      = 6;
  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned TW         = (OFM_W + TI - 1) / TI;
  localparam int unsigned NSEEN      = OFM_C * OFM_H * OFM_W;
`ifdef OFM_WRITER_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done, err_overflow, err_proto;

  ofm_writer_if #(.OUT_DW(OUT_DW), .ADDR_W(ADDR_W)) bus ();

  ofm_writer #(
    .OUT_DW(OUT_DW), .TI(TI), .OFM_C(OFM_C), .OFM_H(OFM_H), .OFM_W(OFM_W),
    .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       addr;
    logic [OUT_DW-1:0] data;
  } wr_t;

  // Reference model: expected write queue plus layer position counters
  wr_t q[$];
  int  m_st, m_ow, m_oh, m_tw, m_oc;
  bit  m_eovf, m_eproto;
  int  n_cmp, n_err;
  int  writes;
  int  seen [NSEEN];

  function automatic logic [OUT_DW-1:0] mrelu(input logic [OUT_DW-1:0] d);
    if (RELU_ON && $signed(d) < 0) return '0;
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_st = M_IDLE; m_ow = 0; m_oh = 0; m_tw = 0; m_oc = 0;
    m_eovf = 1'b0; m_eproto = 1'b0;
  endtask

  // One clock: drive inputs at negedge, score outputs, advance model, move to next negedge
  task automatic step(input bit st, input bit v0, input bit v1,
                      input logic [OUT_DW-1:0] d0, input logic [OUT_DW-1:0] d1, input bit rdy);
    int  col, need, step_rows;
    bit  pop;
    wr_t e;
    start = st;
    bus.ofm_port0_v = v0; bus.ofm_port1_v = v1;
    bus.ofm_port0 = d0;   bus.ofm_port1 = d1;
    bus.wr_ready = rdy;
    check("wr_valid", 64'(bus.wr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("wr_addr", 64'(bus.wr_addr), 64'(q[0].addr));
      check("wr_data", 64'(bus.wr_data), 64'(q[0].data));
    end
    check("busy", 64'(busy), 64'(m_st == M_RUN || m_st == M_DRAIN));
    check("done", 64'(done), 64'(m_st == M_DONE));
    check("err_overflow", 64'(err_overflow), 64'(m_eovf));
    check("err_proto", 64'(err_proto), 64'(m_eproto));
    if (bus.wr_valid === 1'b1 && rdy) begin
      writes++;
      if (bus.wr_addr < ADDR_W'(NSEEN)) seen[bus.wr_addr]++;
    end

    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    case (m_st)
      M_DRAIN: if (q.size() == 0) m_st = M_DONE;
      M_RUN: begin
        if (!v0 && v1) m_eproto = 1'b1;
        else if (v0) begin
          col  = m_tw * TI + m_ow;
          need = (col < OFM_W) ? (v1 ? 2 : 1) : 0;
          if (need > 0) begin
            if (FIFO_DEPTH - q.size() < need) m_eovf = 1'b1;
            else begin
              e.addr = m_oc * OFM_H * OFM_W + m_oh * OFM_W + col;
              e.data = mrelu(d0);
              q.push_back(e);
              if (v1) begin
                e.addr = e.addr + OFM_W;
                e.data = mrelu(d1);
                q.push_back(e);
              end
            end
          end
          step_rows = v1 ? 2 : 1;
          m_ow++;
          if (m_ow == TI) begin
            m_ow = 0;
            m_oh += step_rows;
            if (m_oh >= OFM_H) begin
              m_oh = 0;
              m_tw++;
              if (m_tw == TW) begin
                m_tw = 0;
                m_oc++;
                if (m_oc == OFM_C) m_st = M_DRAIN;
              end
            end
          end
        end
      end
      default: if (st) begin
        m_st = M_RUN; m_ow = 0; m_oh = 0; m_tw = 0; m_oc = 0;
        m_eovf = 1'b0; m_eproto = 1'b0;
      end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [OUT_DW-1:0] rnd();
    return OUT_DW'($urandom);
  endfunction

  initial begin
    logic [OUT_DW-1:0] neg3, neg7;
    bit once_ok;
    int r;
    n_cmp = 0; n_err = 0; writes = 0;
    neg3 = OUT_DW'(-3);
    neg7 = OUT_DW'(-7);
    rst_n = 1'b0; start = 1'b0;
    bus.ofm_port0 = '0; bus.ofm_port1 = '0;
    bus.ofm_port0_v = 1'b0; bus.ofm_port1_v = 1'b0; bus.wr_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_errs", 64'({err_overflow, err_proto}), 64'd0);
    rst_n = 1'b1;

    // First pair beat, then the rest of the layer in tile order with wr_ready high
    step(1, 0, 0, '0, '0, 1);
    step(0, 1, 1, OUT_DW'(5), neg3, 1);
    check("first_addr", 64'(bus.wr_addr), 64'd0);
    check("first_data", 64'(bus.wr_data), 64'd5);
    step(0, 0, 0, '0, '0, 1);
    check("second_addr", 64'(bus.wr_addr), 64'd6);
    check("second_data", 64'(bus.wr_data), RELU_ON ? 64'd0 : 64'(neg3));
    for (int t = 0; t < int'(OFM_C * TW); t++)
      for (int k = 0; k < 2 * int'(TI); k++)
        if (!(t == 0 && k == 0)) step(0, 1, k < int'(TI), rnd(), rnd(), 1);
    for (int i = 0; i < 40 && done !== 1'b1; i++) step(0, 0, 0, '0, '0, 1);
    once_ok = 1'b1;
    for (int i = 0; i < int'(NSEEN); i++) if (seen[i] != 1) once_ok = 1'b0;
    check("layer_writes", 64'(writes), 64'd36);
    check("layer_addr_once", 64'(once_ok), 64'd1);
    check("layer_done", 64'(done), 64'd1);
    check("layer_busy", 64'(busy), 64'd0);
    check("layer_errs", 64'({err_overflow, err_proto}), 64'd0);

    // Backpressure: 4 pair beats fill the FIFO, the 5th is dropped
    step(1, 0, 0, '0, '0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, rnd(), rnd(), 0);
    check("ovf_flag", 64'(err_overflow), 64'd1);
    check("ovf_full", 64'(bus.wr_valid), 64'd1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, '0, '0, 1);
    // Protocol error leaves position untouched; next single beat lands at row 2, col 1
    step(0, 0, 1, rnd(), rnd(), 1);
    check("proto_flag", 64'(err_proto), 64'd1);
    check("proto_nopush", 64'(bus.wr_valid), 64'd0);
    step(0, 1, 0, rnd(), rnd(), 1);
    check("after_drop_addr", 64'(bus.wr_addr), 64'd13);

    // Random mix of beats and wr_ready until the layer completes
    for (int i = 0; i < 2000 && m_st != M_DONE; i++) begin
      r = $urandom_range(0, 9);
      step(0, r <= 7, (r <= 4) || (r == 8), rnd(), rnd(), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40 && m_st != M_DONE; i++) step(0, 0, 0, '0, '0, 1);
    check("rand_done", 64'(done), 64'd1);

    // Start clears sticky errors
    step(1, 0, 0, '0, '0, 0);
    check("start_clr_ovf", 64'(err_overflow), 64'd0);
    check("start_clr_proto", 64'(err_proto), 64'd0);

    // Asynchronous reset with 3 entries queued
    for (int i = 0; i < 3; i++) step(0, 1, 0, rnd(), rnd(), 0);
    check("pre_rst_valid", 64'(bus.wr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.wr_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, '0, '0, 1);
    step(0, 1, 0, OUT_DW'(9), '0, 1);
    check("post_rst_addr", 64'(bus.wr_addr), 64'd0);
    check("post_rst_data", 64'(bus.wr_data), 64'd9);
    step(0, 1, 0, neg7, '0, 1);
    check("neg_addr", 64'(bus.wr_addr), 64'd1);
    check("neg_data", 64'(bus.wr_data), RELU_ON ? 64'd0 : 64'(neg7));
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ofm_writer.md
Name: ofm_writer

Overview:
- Sink-side collector for the conv kernel's dual output ports (ofm_port0/ofm_port1 with per-port valids).
- Converts the kernel's tile-ordered output stream into linear raster addresses: channel-major, then row, then column.
- Buffers samples in a small FIFO and writes them out over a valid/ready memory-write interface.
- The kernel has no backpressure, so FIFO overflow is detected and flagged, never stalled.

Parameters:
- OUT_DW, 25, ofm sample width (signed)
- TI, 16, tile width in columns per output beat sequence
- OFM_C, 8, output channels per layer
- OFM_H, 61, output rows per channel
- OFM_W, 61, output columns per channel; TW = ceil(OFM_W/TI) tile columns (derived localparam)
- ADDR_W, 18, write address width; must satisfy 2^ADDR_W >= OFM_C*OFM_H*OFM_W
- FIFO_DEPTH, 16, entries, power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, arms block for one layer
- ofm_port0  in  OUT_DW  sample for row oh
- ofm_port1  in  OUT_DW  sample for row oh+1
- ofm_port0_v  in  1  port0 valid
- ofm_port1_v  in  1  port1 valid
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  ADDR_W  linear address oc*OFM_H*OFM_W + oh*OFM_W + col
- wr_data  out  OUT_DW  sample
- busy  out  1  high in RUN and DRAIN
- done  out  1  level, high in DONE until next start
- err_overflow  out  1  sticky, cleared by start
- err_proto  out  1  sticky, cleared by start

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters ow, oh, tw, oc = 0; FIFO empty.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start -> RUN:
  - counters cleared; errors cleared; done cleared.
  - start in RUN or DRAIN is ignored.
- In IDLE/DONE, ofm valids are ignored; no push, no error.
- Beat in RUN, both valids high (pair beat):
  - col = tw*TI + ow.
  - If col < OFM_W, push (addr(oh), port0) then (addr(oh+1), port1); port0 entry pops first.
  - ow++. At ow == TI-1: ow = 0, oh += 2.
- Beat in RUN, port0_v only (single beat):
  - Push (addr(oh), port0) if col < OFM_W.
  - ow++. At wrap: oh += 1.
- Beat in RUN, port1_v only:
  - Set err_proto, push nothing, counters unchanged.
- Row wrap: when oh reaches >= OFM_H at an ow wrap:
  - oh = 0, tw++.
  - When tw reaches TW: tw = 0, oc++.
  - When oc reaches OFM_C: FSM -> DRAIN.
- Clipping: beats with col >= OFM_W still advance counters but write nothing.
- FIFO:
  - Show-ahead. wr_valid = !empty; wr_addr/wr_data = head entry.
  - Pop when wr_valid && wr_ready.
  - Push-to-wr_valid latency is 1 cycle.
  - Pop and push in the same cycle are allowed; free space is evaluated including that cycle's pop.
- Overflow: if free space < entries needed by a beat:
  - Whole beat is dropped; no partial pair.
  - err_overflow set.
  - Counters still advance, so addressing stays aligned.
- DRAIN -> DONE when the FIFO is empty; done = 1, busy = 0.
- Address arithmetic is unsigned, ADDR_W bits, computed at push time. Data is passed through unmodified (unless the Optional Feature is enabled).
- Asynchronous reset mid-operation flushes the FIFO; no write completes after rst_n falls.

Optional Feature:
- Macro OFM_WRITER_RELU_EN.
- Defined: each sample with sign bit = 1 is replaced by 0 at push time; addresses are unaffected.
- Undefined: samples are written bit-exact.

Test Plan:
- Params OFM_C=2, OFM_H=3, OFM_W=6, TI=4, FIFO_DEPTH=8; start; pair beat port0=5, port1=-3, wr_ready=1 -> next cycle wr_addr=0 data=5; following cycle wr_addr=6 data=-3 (25-bit two's complement).
- Same params, full layer with wr_ready=1: per tile, 4 pair beats then 4 single beats -> exactly 36 writes; addresses 0..35 each exactly once; done=1 after last pop; busy=0; no errors.
- Clipping, same params: tile tw=1 beats at ow=2,3 (col 6,7) -> no write; next beat's col/address continues correctly.
- Backpressure, wr_ready=0: 5 consecutive pair beats -> first 4 fill FIFO (8 entries); 5th dropped; err_overflow=1; after wr_ready=1, the 8 entries drain in order. Next accepted beat has ow = 1 of the next row-pair.
- Protocol error: port1_v=1, port0_v=0 -> err_proto=1, no push, ow unchanged; a following start clears err_proto.
- Reset mid-layer with FIFO holding 3 entries -> wr_valid=0 immediately, FSM=IDLE. Subsequent start + first beat writes addr 0.
- With OFM_WRITER_RELU_EN defined: port0=-7 -> wr_data=0; port0=9 -> wr_data=9.
